// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator-machine control path: opcodes, ALU
// function selects, sequencer states and ring-counter phase bit positions.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_STA = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_OR     = 3'd4;
  localparam logic [2:0] ALU_XOR    = 3'd5;

  localparam int T0_B = 3;
  localparam int T1_B = 2;
  localparam int T2_B = 1;
  localparam int T3_B = 0;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic b_load;
    logic acc_load;
    logic mem_we;
    logic out_load;
    logic is_jump;
    logic is_halt;
  } ctl_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode/phase decode into datapath strobes, ALU select and
// branch resolution. Everything is gated by en, so idle cycles decode to zero.
module instr_decode
  import cpu_pkg::*;
(
  input  logic       en,
  input  logic       is_t1,
  input  logic       is_t2,
  input  logic [3:0] opcode,
  input  logic       z,
  input  logic       c,
  output ctl_t       ctl,
  output logic [2:0] alu_op
);

  logic uses_b;

  always_comb begin
    uses_b = (opcode >= OP_LDA) && (opcode <= OP_XOR);
    ctl    = '0;
    alu_op = ALU_PASS_B;
    if (en && is_t1) begin
      ctl.b_load = uses_b;
    end else if (en && is_t2) begin
      ctl.acc_load = uses_b;
      unique case (opcode)
        OP_ADD:  alu_op = ALU_ADD;
        OP_SUB:  alu_op = ALU_SUB;
        OP_AND:  alu_op = ALU_AND;
        OP_OR:   alu_op = ALU_OR;
        OP_XOR:  alu_op = ALU_XOR;
        OP_STA:  ctl.mem_we   = 1'b1;
        OP_JMP:  ctl.is_jump  = 1'b1;
        OP_JZ:   ctl.is_jump  = z;
        OP_JC:   ctl.is_jump  = c;
        OP_OUT:  ctl.out_load = 1'b1;
        OP_HLT:  ctl.is_halt  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer driven by the ring counter's one-hot phase vector.
// Owns PC, IR, Z/C flags and the RUN/HALTED/FAULT state machine.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [3:0]        t,
  input  logic [ADDR_W+3:0] instr,
  input  logic              alu_z,
  input  logic              alu_c,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        alu_op,
  output logic              b_load,
  output logic              acc_load,
  output logic              mem_we,
  output logic              out_load,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W+3:0] ir,
  output logic              calc_done,
  output logic              fault
);

  seq_state_e state, state_d;
  logic [3:0] t_q;
  logic       z_q, c_q;
  logic       onehot, illegal, step, active;
  logic [3:0] opcode;
  ctl_t       ctl;

  assign opcode  = ir[ADDR_W+3:ADDR_W];
  assign onehot  = is_onehot4(t);
  assign illegal = !onehot && (t != 4'd0);
  // A phase acts only on the cycle it changes, so a parked ring is inert.
  assign step    = onehot && (t != t_q);
  assign active  = step && (state == S_RUN);

  instr_decode u_dec (
    .en     (active),
    .is_t1  (t[T1_B]),
    .is_t2  (t[T2_B]),
    .opcode (opcode),
    .z      (z_q),
    .c      (c_q),
    .ctl    (ctl),
    .alu_op (alu_op)
  );

  assign b_load   = ctl.b_load;
  assign acc_load = ctl.acc_load;
  assign mem_we   = ctl.mem_we;
  assign out_load = ctl.out_load;
  assign mem_addr = t[T0_B] ? pc : ir[ADDR_W-1:0];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= S_RUN;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_RUN: begin
        if (illegal)          state_d = S_FAULT;
        else if (ctl.is_halt) state_d = S_HALTED;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      t_q       <= 4'd0;
      pc        <= '0;
      ir        <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      calc_done <= 1'b0;
      fault     <= 1'b0;
    end else begin
      t_q       <= t;
      calc_done <= calc_done | (state_d != S_RUN);
      fault     <= fault | (state_d == S_FAULT);
      if (active && t[T0_B]) begin
        ir <= instr;
        pc <= pc + ADDR_W'(1);
      end
      // Jump target overwrites the PC already advanced at T0.
      if (ctl.is_jump) pc <= ir[ADDR_W-1:0];
      if (ctl.acc_load) begin
        z_q <= alu_z;
        c_q <= ((opcode == OP_ADD) || (opcode == OP_SUB)) ? alu_c : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: ROM model on mem_addr, phases driven
// on the falling edge and outputs sampled 1ns later.
module tb_control_sequencer;
  localparam logic [3:0] P0 = 4'b1000;
  localparam logic [3:0] P1 = 4'b0100;
  localparam logic [3:0] P2 = 4'b0010;
  localparam logic [3:0] P3 = 4'b0001;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [3:0] t;
  logic [7:0] instr;
  logic       alu_z, alu_c;
  logic [3:0] mem_addr;
  logic [2:0] alu_op;
  logic       b_load, acc_load, mem_we, out_load;
  logic [3:0] pc;
  logic [7:0] ir;
  logic       calc_done, fault;
  logic [7:0] rom [16];

  int pass_cnt = 0;
  int total    = 0;

  control_sequencer #(.ADDR_W(4)) dut (
    .clk(clk), .clr_n(clr_n), .t(t), .instr(instr), .alu_z(alu_z), .alu_c(alu_c),
    .mem_addr(mem_addr), .alu_op(alu_op), .b_load(b_load), .acc_load(acc_load),
    .mem_we(mem_we), .out_load(out_load), .pc(pc), .ir(ir),
    .calc_done(calc_done), .fault(fault)
  );

  always #5 clk = ~clk;
  assign instr = rom[mem_addr];

  task automatic ph(input logic [3:0] v);
    @(negedge clk);
    t = v;
    #1;
  endtask

  task automatic run_instr(input logic z, input logic c);
    alu_z = z; alu_c = c;
    ph(P0); ph(P1); ph(P2); ph(P3);
    alu_z = 1'b0; alu_c = 1'b0;
  endtask

  task automatic do_reset();
    clr_n = 1'b0; t = 4'd0; alu_z = 1'b0; alu_c = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    @(negedge clk); @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; t = 4'd0; alu_z = 1'b0; alu_c = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    #1;
    total++; if ({pc, ir} !== 12'h000) $display("FAIL rst_pc_ir got %h exp 000", {pc, ir}); else pass_cnt++;
    total++; if ({calc_done, fault} !== 2'b00) $display("FAIL rst_done_fault got %b exp 00", {calc_done, fault}); else pass_cnt++;
    total++; if ({b_load, acc_load, mem_we, out_load} !== 4'b0000) $display("FAIL rst_strobes got %b exp 0000", {b_load, acc_load, mem_we, out_load}); else pass_cnt++;
    total++; if ({mem_addr, alu_op} !== 7'd0) $display("FAIL rst_addr_op got %h exp 0", {mem_addr, alu_op}); else pass_cnt++;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_program();
    do_reset();
    rom[0] = 8'h18; rom[1] = 8'h29; rom[2] = 8'hE0; rom[3] = 8'hF0;
    ph(P0);
    total++; if (mem_addr !== 4'd0) $display("FAIL prog_fetch_addr got %h exp 0", mem_addr); else pass_cnt++;
    ph(P1);
    total++; if (b_load !== 1'b1) $display("FAIL prog_b_load0 got %b exp 1", b_load); else pass_cnt++;
    total++; if ({ir, pc, mem_addr} !== 16'h1818) $display("FAIL prog_ir_pc0 got %h exp 1818", {ir, pc, mem_addr}); else pass_cnt++;
    ph(P2);
    total++; if ({acc_load, alu_op} !== 4'b1_000) $display("FAIL prog_lda_exec got %b exp 1000", {acc_load, alu_op}); else pass_cnt++;
    ph(P3);
    total++; if ({b_load, acc_load, mem_we, out_load} !== 4'b0000) $display("FAIL prog_t3_idle got %b exp 0000", {b_load, acc_load, mem_we, out_load}); else pass_cnt++;
    ph(P0); ph(P1);
    total++; if (b_load !== 1'b1) $display("FAIL prog_b_load1 got %b exp 1", b_load); else pass_cnt++;
    ph(P2);
    total++; if ({acc_load, alu_op} !== 4'b1_001) $display("FAIL prog_add_exec got %b exp 1001", {acc_load, alu_op}); else pass_cnt++;
    ph(P3); ph(P0); ph(P1);
    total++; if (b_load !== 1'b0) $display("FAIL prog_out_no_b got %b exp 0", b_load); else pass_cnt++;
    ph(P2);
    total++; if ({out_load, acc_load} !== 2'b10) $display("FAIL prog_out_load got %b exp 10", {out_load, acc_load}); else pass_cnt++;
    ph(P3); ph(P0); ph(P1); ph(P2);
    total++; if (calc_done !== 1'b0) $display("FAIL prog_done_early got %b exp 0", calc_done); else pass_cnt++;
    ph(P3);
    total++; if ({calc_done, pc} !== 5'b1_0100) $display("FAIL prog_halt got %b exp 10100", {calc_done, pc}); else pass_cnt++;
    ph(P0); ph(P1);
    total++; if ({ir, pc, b_load} !== 13'b11110000_0100_0) $display("FAIL prog_halted_idle got %b exp 1111000001000", {ir, pc, b_load}); else pass_cnt++;
  endtask

  task automatic run_branch(input string name, input logic [7:0] i0, input logic [7:0] i1,
                            input logic z, input logic c, input logic [3:0] exp_pc);
    do_reset();
    rom[0] = i0; rom[1] = i1;
    run_instr(z, c);
    run_instr(1'b0, 1'b0);
    total++; if (pc !== exp_pc) $display("FAIL %s_pc got %h exp %h", name, pc, exp_pc); else pass_cnt++;
    ph(P0);
    total++; if (mem_addr !== exp_pc) $display("FAIL %s_addr got %h exp %h", name, mem_addr, exp_pc); else pass_cnt++;
  endtask

  task automatic test_branch();
    run_branch("jz_taken",  8'h35, 8'h96, 1'b1, 1'b0, 4'd6);
    run_branch("jz_not",    8'h35, 8'h96, 1'b0, 1'b0, 4'd2);
    run_branch("jc_taken",  8'h21, 8'hA9, 1'b0, 1'b1, 4'd9);
    run_branch("jc_and_clr", 8'h41, 8'hA9, 1'b0, 1'b1, 4'd2);
  endtask

  task automatic test_pc_wrap();
    do_reset();
    rom[0] = 8'h8F;
    run_instr(1'b0, 1'b0);
    total++; if (pc !== 4'd15) $display("FAIL wrap_jmp got %h exp f", pc); else pass_cnt++;
    ph(P0); ph(P1);
    total++; if (pc !== 4'd0) $display("FAIL wrap_pc got %h exp 0", pc); else pass_cnt++;
    ph(P2); ph(P3); ph(P0);
    total++; if (mem_addr !== 4'd0) $display("FAIL wrap_addr got %h exp 0", mem_addr); else pass_cnt++;
  endtask

  task automatic test_parked();
    do_reset();
    rom[0] = 8'hB3; rom[1] = 8'hC4;
    repeat (6) ph(P0);
    total++; if ({pc, ir} !== 12'h1B3) $display("FAIL park_fetch got %h exp 1b3", {pc, ir}); else pass_cnt++;
  endtask

  task automatic test_fault();
    do_reset();
    rom[0] = 8'h18;
    ph(4'b1100);
    total++; if (fault !== 1'b0) $display("FAIL fault_early got %b exp 0", fault); else pass_cnt++;
    ph(P0);
    total++; if ({fault, calc_done} !== 2'b11) $display("FAIL fault_set got %b exp 11", {fault, calc_done}); else pass_cnt++;
    ph(P1);
    total++; if ({b_load, pc, ir} !== 13'd0) $display("FAIL fault_no_fetch got %h exp 0", {b_load, pc, ir}); else pass_cnt++;
    ph(P2);
    total++; if ({acc_load, mem_we, out_load} !== 3'b000) $display("FAIL fault_no_exec got %b exp 000", {acc_load, mem_we, out_load}); else pass_cnt++;
    do_reset();
    total++; if ({fault, calc_done} !== 2'b00) $display("FAIL fault_clear got %b exp 00", {fault, calc_done}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rom[0] = 8'h73;
    ph(P0); ph(P1); ph(P2);
    total++; if (mem_we !== 1'b1) $display("FAIL mid_sta_we got %b exp 1", mem_we); else pass_cnt++;
    #1 clr_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) $display("FAIL mid_we_drop got %b exp 0", mem_we); else pass_cnt++;
    total++; if ({pc, ir, mem_addr, calc_done, fault} !== 18'd0) $display("FAIL mid_regs got %h exp 0", {pc, ir, mem_addr, calc_done, fault}); else pass_cnt++;
    @(negedge clk);
    t = 4'd0;
    clr_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_program();
    test_branch();
    test_pc_wrap();
    test_parked();
    test_fault();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Instruction sequencer downstream of `Ring_counter`. Consumes its 4-bit one-hot phase vector, fetches and decodes 8-bit instructions, and issues per-phase register/ALU/memory strobes to the datapath. It also produces `calc_done`, which the ring counter uses to stop phase rotation. It owns the PC, IR and the Z/C flags of the accumulator machine.

## Interface
- `ADDR_W`, default 4: PC and operand width; the instruction is `{opcode[3:0], operand[ADDR_W-1:0]}`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `t`  in  4  phase vector from the ring counter; `t[3]`=T0 fetch, `t[2]`=T1 operand, `t[1]`=T2 execute, `t[0]`=T3 retire.
- `instr`  in  4+ADDR_W  program word at `mem_addr`, combinational.
- `alu_z`, `alu_c`  in  1 each  combinational ALU zero/carry for the current `alu_op`.
- `mem_addr`  out  ADDR_W  equals `pc` during T0, otherwise `ir[ADDR_W-1:0]`.
- `alu_op`  out  3  ALU function select.
- `b_load`, `acc_load`, `mem_we`, `out_load`  out  1 each  single-cycle datapath strobes.
- `pc`  out  ADDR_W, `ir`  out  4+ADDR_W  architectural registers.
- `calc_done`  out  1  halted or faulted; sticky until reset.
- `fault`  out  1  illegal phase vector seen; sticky.

## Operation
- **Step detect:** register `t_q` holds the previous `t`, reset value 4'b0000.
  - `step = (t != t_q)` and `t` is one-hot.
  - All actions occur only on a step cycle, so a parked ring (held at T0 after halt) never re-fetches.
- **FSM states:** RUN (reset state), HALTED, FAULT.
  - RUN → HALTED: at the T2 step of HLT.
  - RUN → FAULT: whenever `t` is neither one-hot nor 4'b0000.
  - HALTED and FAULT exit only on reset.
  - No strobes are issued outside RUN.
- **T0:** `ir <= instr`; `pc <= pc+1`, wrapping from 2^ADDR_W−1 to 0.
- **T1:** `b_load=1` for LDA, ADD, SUB, AND, OR and XOR (B register <= mem[operand]).
- **T2, by opcode:**
  - 0 NOP: no action.
  - 1 LDA: `alu_op=PASS_B`, `acc_load`.
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: matching `alu_op`, `acc_load`.
  - 7 STA: `mem_we`.
  - 8 JMP: `pc <= operand`.
  - 9 JZ: jump if Z=1. A JC: jump if C=1.
  - E OUT: `out_load`.
  - F HLT.
  - B, C, D: NOP.
- **Flags, latched at the T2 edge with `acc_load`:**
  - ADD/SUB: Z<=`alu_z`, C<=`alu_c`.
  - LDA/AND/OR/XOR: Z<=`alu_z`, C<=0.
  - Other opcodes hold the flags.
- **T3:** no action; reserved retire slot.
- **Outside a strobe:** `alu_op` = PASS_B (3'b000).

## Timing
- Strobes are combinational from `state`, `t`, `t_q` and `ir`. They are high for exactly the one step cycle, and the datapath captures at that cycle's closing edge.
- IR and PC update at the T0 closing edge. A jump overwrites the already-incremented PC at the T2 edge.
- `calc_done` is registered and rises the cycle after the HLT T2 step. The ring then parks at T0 two edges later.
- Reset values: `pc`=0, `ir`=0, Z=C=0, `t_q`=0, state=RUN, `calc_done`=0, `fault`=0, all strobes 0, `mem_addr`=0.
- Reset mid-instruction takes effect immediately. A strobe in flight deasserts without waiting for a clock edge.
- Fetch-to-execute latency is 2 steps. CPI is 4 steps.

## Structure
- Package `cpu_pkg`:
  - opcode localparams (`OP_NOP`…`OP_HLT`);
  - `alu_op` encodings: PASS_B=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5;
  - FSM state enum;
  - phase index constants `T0_B`=3 … `T3_B`=0.
- Sub-module `instr_decode`: purely combinational map from opcode + phase to strobes, `alu_op` and `is_jump`.
- Top level holds `t_q`, PC, IR, flags, the FSM and step detection.

## Test plan
- ROM {0:LDA 8, 1:ADD 9, 2:OUT, 3:HLT} with normal rotation:
  - `b_load` at T1 of instructions 0 and 1;
  - `acc_load` with `alu_op`=0 then 1;
  - `out_load` at T2 of instruction 2;
  - `calc_done`=1 one cycle after HLT T2, with `pc`=4.
- Taken and not-taken branch:
  - SUB with `alu_z`=1, then JZ 6 → `pc`=6 after T2;
  - repeat with `alu_z`=0 → `pc`=next sequential address.
- PC wrap: `pc`=15 executing NOP → `pc`=0 after T0, and `mem_addr`=0 on the next T0.
- Parked phase: hold `t`=4'b1000 for 6 cycles → exactly one IR load and one PC increment.
- Illegal phase: `t`=4'b1100 → `fault`=1 and `calc_done`=1 next cycle; no strobes for any later `t` until `clr_n` pulses.
- Reset mid-execute: drop `clr_n` during the STA T2 cycle → `mem_we` falls without a clock edge; all registers read their reset values.
